fetch_unit: RTL
===============

# fetch_unit

Instruction fetch stage that sits directly upstream of the single-cycle datapath's instruction path. It owns the architectural fetch PC, issues word requests to instruction memory over a valid/ready handshake with variable response latency, buffers returned instructions with their PCs in a small FIFO, and hands them to decode over a valid/ready interface. A redirect input (branch/jump target) flushes buffered and in-flight instructions and restarts fetch at the new PC.

## Interface
- RESET_PC, 32'h00003000, fetch PC loaded on reset
- FIFO_DEPTH, 2, instruction buffer entries; power of two, ≥2
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- imem_req_valid  out  1  request to instruction memory
- imem_req_addr  out  32  word address of request (bits [1:0] always 0)
- imem_req_ready  in  1  memory accepts request
- imem_resp_valid  in  1  response data valid
- imem_resp_data  in  32  returned instruction word
- redirect_valid  in  1  redirect fetch (one-cycle pulse)
- redirect_pc  in  32  redirect target; bits [1:0] ignored (forced 0)
- out_valid  out  1  instruction available to decode
- out_instr  out  32  instruction at FIFO head
- out_pc  out  32  PC of out_instr
- out_ready  in  1  decode consumes head
- fetch_count  out  32  instructions delivered (only with FETCH_PERF_EN)

## Operation
- States: IDLE (may issue), WAIT (one request in flight, response kept), DROP (one request in flight, response discarded). Reset state IDLE.
- At most one outstanding request. imem_req_valid = (state==IDLE) && (count < FIFO_DEPTH) && !redirect_valid && !reset.
- imem_req_addr = fetch_pc. Accept (valid&&ready): req_pc <= fetch_pc, fetch_pc <= fetch_pc+4 (mod 2^32 wrap), IDLE→WAIT.
- WAIT & imem_resp_valid: push {req_pc, imem_resp_data}, →IDLE. DROP & imem_resp_valid: discard, →IDLE.
- imem_resp_valid outside WAIT/DROP is ignored.
- Redirect (highest priority): FIFO emptied, fetch_pc <= {redirect_pc[31:2],2'b00}; request not issued that cycle. State: IDLE→IDLE; WAIT→DROP; DROP→DROP; WAIT or DROP with imem_resp_valid same cycle → IDLE (response discarded, not pushed).
- Pop when out_valid && out_ready && !redirect_valid. Push and pop in same cycle allowed; count unchanged.
- out_valid = count != 0; out_instr/out_pc = 0 when empty.
- Reset mid-operation: FIFO emptied, state IDLE, fetch_pc = RESET_PC; a response to a pre-reset request arriving after reset is ignored (state IDLE).

## Timing
- Reset values: imem_req_valid 0, imem_req_addr RESET_PC, out_valid 0, out_instr 0, out_pc 0, fetch_count 0.
- imem_resp_valid earliest one cycle after acceptance; zero-latency responses unsupported.
- With 1-cycle memory and out_ready=1: request cycle N, response N+1, out_valid at N+2; steady throughput one instruction per 2 cycles.
- Redirect in cycle N: out_valid 0 in N+1; first request to target at N+1 if state IDLE, else after the dropped response returns.
- FIFO full: imem_req_valid held 0 until a pop.

## Configuration
- FETCH_PERF_EN defined: fetch_count port present, increments by 1 on every pop (wraps at 2^32), cleared by reset only.
- Undefined: port and counter absent; all other behaviour identical.

## Structure
- Package fetch_pkg: state enum {IDLE, WAIT, DROP}, default reset PC constant 32'h00003000, PC/instruction width constant 32.
- Sub-module fetch_fifo: synchronous FIFO of 64-bit {pc, instr} entries with push, pop, flush, count, head outputs; fetch_unit holds FSM and PC.

## Test plan
- Reset release, 1-cycle memory, out_ready=1 -> requests 0x3000, 0x3004, 0x3008; out_pc sequence identical, out_valid first at cycle 2.
- out_ready=0, FIFO_DEPTH=2 -> exactly two requests issued, then imem_req_valid 0; raise out_ready -> fetch resumes at 0x3008.
- Redirect to 0x4002 while WAIT, response arrives 3 cycles later -> response discarded, next request address 0x4000, FIFO empty meanwhile.
- Redirect in same cycle as response with FIFO holding one entry -> out_valid 0 next cycle, nothing pushed, state IDLE.
- redirect_pc 0xFFFFFFFC -> requests 0xFFFFFFFC then 0x00000000 (wrap).
- FETCH_PERF_EN: 5 pops -> fetch_count 5; reset -> 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_3000;

  // IDLE may issue a request; WAIT keeps the in-flight response; DROP discards it.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of {pc, instr} entries; flush empties it in one cycle.
// Head reads as zero when the FIFO is empty.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    push,
  input  fetch_entry_t            push_data,
  input  logic                    pop,
  output logic [$clog2(DEPTH):0]  count,
  output fetch_entry_t            head
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  fetch_entry_t     mem_q [DEPTH];
  fetch_entry_t     mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  // Next pointer/count/storage; flush overrides any push or pop.
  always_comb begin
    do_push  = push && (count_q != FULL_CNT);
    do_pop   = pop && (count_q != '0);
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are only meaningful below count, so no reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Head and occupancy outputs.
  always_comb begin
    count = count_q;
    head  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, keeps one imem request in flight,
// buffers responses with their PCs and hands them to decode. A redirect flushes
// the buffer and drops any in-flight response.
// Optional: define FETCH_PERF_EN to add the fetch_count delivered-instruction counter.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int unsigned     FIFO_DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  output logic             imem_req_valid,
  output logic [XLEN-1:0]  imem_req_addr,
  input  logic             imem_req_ready,
  input  logic             imem_resp_valid,
  input  logic [XLEN-1:0]  imem_resp_data,
  input  logic             redirect_valid,
  input  logic [XLEN-1:0]  redirect_pc,
  output logic             out_valid,
  output logic [XLEN-1:0]  out_instr,
  output logic [XLEN-1:0]  out_pc,
  input  logic             out_ready
`ifdef FETCH_PERF_EN
  ,
  output logic [XLEN-1:0]  fetch_count
`endif
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;

  logic            req_fire;
  logic            fifo_push, fifo_pop;
  fetch_entry_t    fifo_entry, fifo_head;
  logic [CNT_W-1:0] fifo_count;

  fetch_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .flush    (redirect_valid),
    .push     (fifo_push),
    .push_data(fifo_entry),
    .pop      (fifo_pop),
    .count    (fifo_count),
    .head     (fifo_head)
  );

  // Request/handshake outputs, FSM next state and PC updates; redirect wins over all.
  always_comb begin
    imem_req_valid = (state_q == IDLE) && (fifo_count < FULL_CNT) && !redirect_valid && !reset;
    imem_req_addr  = fetch_pc_q;
    req_fire       = imem_req_valid && imem_req_ready;
    out_valid      = (fifo_count != '0);
    out_pc         = fifo_head.pc;
    out_instr      = fifo_head.instr;
    fifo_pop       = out_valid && out_ready && !redirect_valid;
    fifo_push      = 1'b0;
    fifo_entry     = '{pc: req_pc_q, instr: imem_resp_data};
    state_d        = state_q;
    fetch_pc_d     = fetch_pc_q;
    req_pc_d       = req_pc_q;
    if (redirect_valid) begin
      fetch_pc_d = word_align(redirect_pc);
      // A response coinciding with the redirect retires the old request immediately.
      if (state_q != IDLE && !imem_resp_valid) begin
        state_d = DROP;
      end else begin
        state_d = IDLE;
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_fire) begin
            req_pc_d   = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + 32'd4;
            state_d    = WAIT;
          end
        end
        WAIT: begin
          if (imem_resp_valid) begin
            fifo_push = 1'b1;
            state_d   = IDLE;
          end
        end
        DROP: begin
          if (imem_resp_valid) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM state and PC registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
    end
  end

`ifdef FETCH_PERF_EN
  logic [XLEN-1:0] fetch_count_q, fetch_count_d;

  // Delivered-instruction counter; advances on every pop, wraps naturally.
  always_comb begin
    fetch_count_d = fetch_count_q + XLEN'(fifo_pop);
    fetch_count   = fetch_count_q;
  end

  // Counter register, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_count_q <= '0;
    end else begin
      fetch_count_q <= fetch_count_d;
    end
  end
`endif

endmodule
